// File: rtl/lfsr_range_rng.sv
// Purpose: unbiased random value in [min_val, max_val] per request, by rejection sampling a Fibonacci LFSR.
// Latency: out_valid rises 2 cycles after acceptance at best, 1+MAX_TRIES cycles at worst.
// Backpressure: result is held in HOLD until out_ready; req_ready stays low from acceptance until the result is taken.
// Build option: define RNG_REJECT_STATS_EN to add the 16-bit saturating reject_cnt output.
module lfsr_range_rng #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LFSR_W    = 16,
    parameter logic [31:0] SEED      = 32'h0000_ACE1,
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WIDTH-1:0]  min_val,
    input  logic [WIDTH-1:0]  max_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  random_num,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic              fallback
`ifdef RNG_REJECT_STATS_EN
    ,
    output logic [15:0]       reject_cnt
`endif
);

    // Seed as seen by the LFSR: truncated or zero-extended to the register length.
    localparam logic [LFSR_W-1:0] SEED_V = LFSR_W'(SEED);

    // Parameter legality is enforced at elaboration so a bad instance never builds.
    generate
        if (!(LFSR_W == 8 || LFSR_W == 16 || LFSR_W == 24 || LFSR_W == 32)) begin : g_bad_lfsr_w
            $error("lfsr_range_rng: LFSR_W must be 8, 16, 24 or 32");
        end
        if (WIDTH < 2 || WIDTH > 32 || WIDTH > LFSR_W) begin : g_bad_width
            $error("lfsr_range_rng: WIDTH must be 2..32 and not exceed LFSR_W");
        end
        if (MAX_TRIES < 1 || MAX_TRIES > 255) begin : g_bad_tries
            $error("lfsr_range_rng: MAX_TRIES must be 1..255");
        end
        if (SEED_V == '0) begin : g_bad_seed
            $error("lfsr_range_rng: SEED must be nonzero after truncation to LFSR_W");
        end
    endgenerate

    // IDLE waits for a request, LOAD derives span/mask from the registered bounds,
    // DRAW tests one candidate per cycle, HOLD presents the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DRAW = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t             state;
    logic [LFSR_W-1:0]  lfsr;
    logic [LFSR_W-1:0]  lfsr_step;
    logic               lfsr_fb;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   span;
    logic [WIDTH-1:0]   mask;
    logic [7:0]         tries;

    logic [WIDTH-1:0]   cand;
    logic               cand_ok;
    logic               last_try;
    logic [WIDTH-1:0]   hi_minus_lo;
    logic [WIDTH-1:0]   fold_val;

    // Smallest all-ones mask covering v: every bit below the MSB of v is set.
    function automatic logic [WIDTH-1:0] smear(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        m = v;
        for (int unsigned sh = 1; sh < WIDTH; sh = sh * 2) begin
            m = m | (m >> sh);
        end
        return m;
    endfunction

    // Feedback taps per supported length (1-based taps 8,6,5,4 / 16,15,13,4 / 24,23,22,17 / 32,22,2,1).
    generate
        if (LFSR_W == 8) begin : g_tap8
            assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        end else if (LFSR_W == 16) begin : g_tap16
            assign lfsr_fb = lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3];
        end else if (LFSR_W == 24) begin : g_tap24
            assign lfsr_fb = lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16];
        end else begin : g_tap32
            assign lfsr_fb = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
        end
    endgenerate

    assign lfsr_step = {lfsr[LFSR_W-2:0], lfsr_fb};

    // Candidate evaluation for the current DRAW cycle.
    always_comb begin
        cand        = lfsr[WIDTH-1:0] & mask;
        cand_ok     = (cand <= span);
        last_try    = (({1'b0, tries} + 9'd1) == 9'(MAX_TRIES));
        hi_minus_lo = hi - lo;
        // A masked candidate never exceeds 2*span+1, so the fold lands back inside [0, span].
        fold_val    = cand - span - WIDTH'(1);
    end

    // LFSR: a seed load wins over stepping in any state; a zero seed falls back to SEED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED_V;
        end else if (seed_load) begin
            lfsr <= (seed_in == '0) ? SEED_V : seed_in;
        end else if (state == DRAW) begin
            lfsr <= lfsr_step;
        end
    end

    // Request/draw/hold sequencing with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            out_valid  <= 1'b0;
            random_num <= '0;
            fallback   <= 1'b0;
            tries      <= '0;
            lo         <= '0;
            hi         <= '0;
            span       <= '0;
            mask       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        // Swapped bounds are legal: order them here.
                        lo        <= (min_val <= max_val) ? min_val : max_val;
                        hi        <= (min_val <= max_val) ? max_val : min_val;
                        tries     <= '0;
                        req_ready <= 1'b0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    // Span subtract and mask smear get their own cycle, off the input path.
                    span  <= hi_minus_lo;
                    mask  <= smear(hi_minus_lo);
                    state <= DRAW;
                end
                DRAW: begin
                    if (cand_ok) begin
                        random_num <= lo + cand;
                        fallback   <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= HOLD;
                    end else if (last_try) begin
                        random_num <= lo + fold_val;
                        fallback   <= 1'b1;
                        out_valid  <= 1'b1;
                        state      <= HOLD;
                    end else begin
                        tries <= tries + 8'd1;
                    end
                end
                HOLD: begin
                    // No skid buffer: the next request is taken one cycle after the result leaves.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RNG_REJECT_STATS_EN
    // Saturating count of rejected candidates, fallback cycles included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reject_cnt <= '0;
        end else if (seed_load) begin
            reject_cnt <= '0;
        end else if (state == DRAW && !cand_ok && reject_cnt != 16'hFFFF) begin
            reject_cnt <= reject_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_range_rng.sv
// Bench for lfsr_range_rng: two instances (MAX_TRIES=8 and MAX_TRIES=1), driven one at a time.
// Stimulus pushes model predictions into a queue; a negedge monitor pops and compares on each handshake.
// Checks value, fallback, latency, range, reset state, hold stability and distribution.
module tb_lfsr_range_rng;

    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        int          dut;
        int unsigned val;
        bit          fb;
        int          lat;
        int          lo;
        int          hi;
        int          acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       out_valid;
    logic [1:0]       out_ready;
    logic [1:0]       seed_load;
    logic [1:0]       fallback;
    logic [1:0][7:0]  min_val;
    logic [1:0][7:0]  max_val;
    logic [1:0][7:0]  random_num;
    logic [1:0][15:0] seed_in;
`ifdef RNG_REJECT_STATS_EN
    logic [1:0][15:0] reject_cnt;
`endif

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] m_lfsr [2];
    bit          stall = 1'b0;
    bit          force_rdy = 1'b1;
    bit          hist_on = 1'b0;
    int          hist [101];
    bit [1:0]    prev_ov = 2'b00;
    int          rise_cyc [2];

    lfsr_range_rng #(.WIDTH(8), .LFSR_W(16), .SEED(32'h0000_ACE1), .MAX_TRIES(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .min_val(min_val[0]), .max_val(max_val[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .random_num(random_num[0]),
        .seed_load(seed_load[0]), .seed_in(seed_in[0]),
        .fallback(fallback[0])
`ifdef RNG_REJECT_STATS_EN
        , .reject_cnt(reject_cnt[0])
`endif
    );

    lfsr_range_rng #(.WIDTH(8), .LFSR_W(16), .SEED(32'h0000_ACE1), .MAX_TRIES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .min_val(min_val[1]), .max_val(max_val[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .random_num(random_num[1]),
        .seed_load(seed_load[1]), .seed_in(seed_in[1]),
        .fallback(fallback[1])
`ifdef RNG_REJECT_STATS_EN
        , .reject_cnt(reject_cnt[1])
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected within %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // 16-bit Fibonacci LFSR, taps 16,15,13,4, shifting left.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
    endfunction

    // Reference: order bounds, draw masked candidates until one fits or tries run out.
    // 'reload' models a seed_load of zero landing on the first draw cycle.
    task automatic predict(input int d, input int a, input int b, input bit reload, output exp_t e);
        int lo, hi, span, mask, lim, cand, draws;
        bit done;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        span = hi - lo;
        mask = 0;
        while (mask < span) mask = mask * 2 + 1;
        lim = (d == 0) ? 8 : 1;
        draws = 0;
        done = 1'b0;
        e.dut = d;
        e.lo = lo;
        e.hi = hi;
        e.val = 0;
        e.fb = 1'b0;
        for (int t = 0; t < lim; t++) begin
            if (!done) begin
                cand = int'(m_lfsr[d][7:0]) & mask;
                m_lfsr[d] = (t == 0 && reload) ? SEED : lfsr_next(m_lfsr[d]);
                draws++;
                if (cand <= span) begin
                    e.val = lo + cand;
                    e.fb = 1'b0;
                    done = 1'b1;
                end else if (t == lim - 1) begin
                    e.val = lo + cand - span - 1;
                    e.fb = 1'b1;
                    done = 1'b1;
                end
            end
        end
        e.lat = 1 + draws;
    endtask

    task automatic issue(input int d, input int a, input int b, input bit reload);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            chk("req_ready_timeout", {31'd0, req_ready[d]}, 32'd1);
            return;
        end
        req_valid[d] = 1'b1;
        min_val[d] = 8'(a);
        max_val[d] = 8'(b);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        predict(d, a, b, reload, e);
        e.acc = cyc;
        exp_q.push_back(e);
        if (reload) begin
            @(posedge clk);
            #1;
            seed_load[d] = 1'b1;
            seed_in[d] = 16'h0000;
            @(posedge clk);
            #1;
            seed_load[d] = 1'b0;
        end
    endtask

    task automatic wait_ov(input int d);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid[d]) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Consumer side: random readiness unless stalled or forced ready.
    initial begin
        out_ready = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                out_ready[d] = stall ? 1'b0 : (force_rdy ? 1'b1 : ($urandom_range(0, 3) != 0));
            end
        end
    end

    // Monitor: record when out_valid rises; compare on every handshake.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (out_valid[d] && !prev_ov[d]) rise_cyc[d] = cyc;
            prev_ov[d] = out_valid[d];
            if (out_valid[d] && out_ready[d]) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(d), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("result_dut", 32'(d), 32'(mon_e.dut));
                    chk("result_value", {24'd0, random_num[d]}, mon_e.val);
                    chk("result_fallback", {31'd0, fallback[d]}, {31'd0, mon_e.fb});
                    chk("result_latency", 32'(rise_cyc[d] - mon_e.acc), 32'(mon_e.lat));
                    chk_range("result_range", int'(random_num[d]), mon_e.lo, mon_e.hi);
                    if (hist_on && d == 0) hist[int'(random_num[d]) - 100]++;
                end
            end
        end
    end

    // Global bound on run time.
    initial begin
        #600000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  held;
        logic [15:0] s;
        int          a, b, cnt, sz, total;

        rst_n = 1'b0;
        req_valid = '0;
        seed_load = '0;
        min_val = '0;
        max_val = '0;
        seed_in = '0;
        m_lfsr[0] = SEED;
        m_lfsr[1] = SEED;
        for (int v = 0; v < 101; v++) hist[v] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", {31'd0, req_ready[d]}, 32'd1);
            chk("rst_out_valid", {31'd0, out_valid[d]}, 32'd0);
            chk("rst_random_num", {24'd0, random_num[d]}, 32'd0);
            chk("rst_fallback", {31'd0, fallback[d]}, 32'd0);
        end
        rst_n = 1'b1;

        // Full range: first result is the seed's low byte
        force_rdy = 1'b1;
        issue(0, 0, 255, 1'b0);
        wait_ov(0);
        chk("first_val", {24'd0, random_num[0]}, 32'h0000_00E1);
        chk("first_fallback", {31'd0, fallback[0]}, 32'd0);
        drain();

        // Degenerate range, back-to-back
        for (int i = 0; i < 10; i++) issue(0, 42, 42, 1'b0);
        drain();

        // Swapped bounds with distribution check
        force_rdy = 1'b0;
        hist_on = 1'b1;
        for (int i = 0; i < 1000; i++) issue(0, 200, 100, 1'b0);
        drain();
        hist_on = 1'b0;
        total = 0;
        for (int v = 0; v < 101; v++) total += hist[v];
        chk("hist_total", total, 1000);
        for (int bk = 0; bk < 10; bk++) begin
            cnt = 0;
            sz = 0;
            for (int v = 0; v <= 100; v++) begin
                if ((v * 10) / 101 == bk) begin
                    cnt += hist[v];
                    sz++;
                end
            end
            // cnt within +-30% of 1000*sz/101, in integer form
            chk_range("hist_bucket", cnt * 1010, 7000 * sz, 13000 * sz);
        end

        // Single-try instance: ~50% fallback on 0..128
        for (int i = 0; i < 200; i++) issue(1, 0, 128, 1'b0);
        for (int i = 0; i < 50; i++) issue(1, $urandom_range(0, 255), $urandom_range(0, 255), 1'b0);
        drain();

        // Random bounds on the multi-try instance
        for (int i = 0; i < 200; i++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            issue(0, a, b, 1'b0);
        end
        drain();

        // Zero seed loaded during the first draw cycle, then fresh-seed sequence
        issue(0, 0, 128, 1'b1);
        for (int i = 0; i < 20; i++) issue(0, 0, 128, 1'b0);
        drain();

        // Nonzero seed loaded while idle
        @(negedge clk);
        s = 16'($urandom_range(1, 65535));
        seed_load[0] = 1'b1;
        seed_in[0] = s;
        @(posedge clk);
        #1;
        seed_load[0] = 1'b0;
        m_lfsr[0] = s;
        for (int i = 0; i < 20; i++) issue(0, $urandom_range(0, 255), $urandom_range(0, 255), 1'b0);
        drain();

        // Stalled consumer: output stable, extra requests ignored, then reset mid-HOLD
        stall = 1'b1;
        @(posedge clk);
        issue(0, 10, 20, 1'b0);
        wait_ov(0);
        held = random_num[0];
        chk("stall_value", {24'd0, held}, exp_q[0].val);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            req_valid[0] = 1'b1;
            min_val[0] = 8'd0;
            max_val[0] = 8'd255;
            @(negedge clk);
            chk("stall_stable", {24'd0, random_num[0]}, {24'd0, held});
            chk("stall_req_ready", {31'd0, req_ready[0]}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid[0]}, 32'd1);
        end
        req_valid[0] = 1'b0;
        chk("stall_pending", exp_q.size(), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid[0]}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready[0]}, 32'd1);
        chk("midrst_random_num", {24'd0, random_num[0]}, 32'd0);
        chk("midrst_fallback", {31'd0, fallback[0]}, 32'd0);
        exp_q.delete();
        m_lfsr[0] = SEED;
        m_lfsr[1] = SEED;
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        issue(0, 0, 255, 1'b0);
        for (int i = 0; i < 10; i++) issue(1, 0, 128, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
